// File: rtl/pipe_stage_latch.sv
// Pipeline stage register: single-entry latch or two-entry skid buffer with
// flush, occupancy and a saturating stall counter.
module pipe_stage_latch #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID_EN   = 1'b1,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_v, skid_v;
  logic              accept, drain;
  logic              load_main, main_from_skid, load_skid;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (drain) begin
            state_next = EMPTY;
          end else if (accept && SKID_EN) begin
            load_skid  = 1'b1;
            state_next = TWO;
          end
        end
        TWO: begin
          if (drain) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    main_v    = (state != EMPTY);
    skid_v    = (state == TWO);
    out_valid = main_v;
    out_data  = main_data;
    occupancy = {1'b0, main_v} + {1'b0, skid_v};
  end

  // Data registers only change on an explicit load, so idle cycles never toggle the payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else if (flush) begin
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      if (load_main) main_data <= main_from_skid ? skid_data : in_data;
      if (load_skid) skid_data <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (flush)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  generate
    if (SKID_EN) begin : g_skid_ready
      // Registered ready breaks the out_ready -> in_ready path; the skid entry absorbs the extra beat.
      logic ready_flop;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_flop <= 1'b1;
        else        ready_flop <= (state_next != TWO);
      end
      assign in_ready = ready_flop;
    end else begin : g_latch_ready
      assign in_ready = !main_v | out_ready;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_latch.md
PIPE_STAGE_LATCH -- requirements
Module: pipe_stage_latch

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of the bundled stage payload (data plus control fields).
REQ-002 SHALL have parameter RESET_VAL, default 0 (DATA_W bits), meaning payload value loaded on reset and flush.
REQ-003 SHALL have parameter SKID_EN, default 1, meaning 1 = two-entry skid buffer with registered in_ready, 0 = single-entry latch.
REQ-004 SHALL have parameter CNT_W, default 8, meaning width of the stall counter.
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous clear of all held entries.
REQ-008 SHALL have port in_valid  input  1  upstream beat present.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port in_ready  output  1  stage can accept a beat this cycle.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid beat.
REQ-012 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the beat this cycle.
REQ-014 SHALL have port occupancy  output  2  number of held beats (0..2).
REQ-015 SHALL have port stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 SHALL define accept = in_valid & in_ready, and drain = out_valid & out_ready.
REQ-017 SHALL hold the main entry (main_data, main_v) and, when SKID_EN=1, the skid entry (skid_data, skid_v).
REQ-018 SHALL drive out_valid = main_v and out_data = main_data with no combinational path from in_data.
REQ-019 SHALL use states EMPTY (main_v=0), ONE (main_v=1, skid_v=0), and TWO (main_v=1, skid_v=1), where TWO is reachable only when SKID_EN=1.
REQ-020 SHALL, with SKID_EN=1, drive in_ready = !skid_v directly from a flop, with no path from out_ready.
REQ-021 SHALL, with SKID_EN=0, drive in_ready = !main_v | out_ready.
REQ-022 SHALL, in EMPTY, on accept load main_data <= in_data and go to ONE; otherwise hold.
REQ-023 SHALL, in ONE, on accept & drain load main_data <= in_data and stay in ONE.
REQ-024 SHALL, in ONE, on drain only go to EMPTY.
REQ-025 SHALL, in ONE, on accept only load skid_data <= in_data and go to TWO when SKID_EN=1; this case cannot occur when SKID_EN=0.
REQ-026 SHALL, in ONE, on neither accept nor drain hold.
REQ-027 SHALL, in TWO, on drain load main_data <= skid_data and go to ONE; otherwise hold; no accept is possible in TWO.
REQ-028 SHALL keep beat order strictly FIFO, with latency in-to-out of one cycle when EMPTY.
REQ-029 SHALL, on flush, clear main_v and skid_v and load both data registers with RESET_VAL, with priority over accept and drain.
REQ-030 SHALL discard any beat accepted in a flush cycle, and SHALL NOT count a drain in a flush cycle as lost (downstream took it).
REQ-031 SHALL leave in_ready combinationally unaffected by flush during the flush cycle; it reflects the pre-flush state.
REQ-032 SHALL drive occupancy = main_v + skid_v.
REQ-033 SHALL increment stall_cnt by 1 each cycle with out_valid & !out_ready, saturating at all-ones with no wrap.
REQ-034 SHALL clear stall_cnt on flush.
REQ-035 SHALL hold data registers unchanged when not loaded, so no spurious payload toggles occur.

Reset
REQ-036 SHALL, while reset=0, asynchronously force main_v=0, skid_v=0, main_data=skid_data=RESET_VAL, and stall_cnt=0.
REQ-037 SHALL give, after reset, out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 (both SKID_EN values), and stall_cnt=0.
REQ-038 SHALL, on reset asserted mid-transfer, lose all held beats; the first beat after deassertion is accepted normally on the first rising edge.

Verification
REQ-039 SHALL cover streaming: SKID_EN=1, out_ready=1, in_valid=1 with data 0x01,0x02,0x03 on consecutive cycles -> out_data 0x01,0x02,0x03 one cycle later, occupancy=1, in_ready stays 1.
REQ-040 SHALL cover backpressure: accept 0xA5, then 0x5A with out_ready=0 -> occupancy=2 and in_ready=0 next cycle; out_ready=1 for 2 cycles -> outputs 0xA5 then 0x5A, in_ready returns to 1.
REQ-041 SHALL cover flush: state TWO, flush=1 with in_valid=1 and in_data=0x77 -> next cycle out_valid=0, occupancy=0, out_data=RESET_VAL, and 0x77 never appears.
REQ-042 SHALL cover stall saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
REQ-043 SHALL cover SKID_EN=0: full with out_ready=1 and in_valid=1 -> in_ready=1 in the same cycle, main replaced, occupancy never exceeds 1.
REQ-044 SHALL cover async reset: reset pulsed low mid-cycle in state ONE -> out_valid=0 immediately, without waiting for a clk edge.
